rf_wport_arbiter: RTL and testbench
===================================

Name: rf_wport_arbiter

Overview:
- Shares the single register-file write port between the writeback stage and the long-latency unit (LLU: multi-cycle divider/multiplier), whose results complete out of band.
- Writeback has priority. LLU results are queued in a small FIFO and drained in port-idle cycles.
- A starvation limiter holds writeback for one cycle when an LLU result has waited too long.
- Sits between Writeback's Wrf bus and the regfile write port.

Parameters:
- DEPTH, 2, LLU result FIFO entries (power of two, >=2)
- MAX_WAIT, 4, consecutive ungranted cycles of a non-empty FIFO before writeback is held (>=1)

Ports:
- clk  input  1  clock
- rstn  input  1  reset; synchronous, active-low
- w_we  input  1  writeback write enable (already qualified with W_valid and no exception)
- w_dest  input  5  writeback destination register
- w_data  input  32  writeback write data
- w_hold  output  1  registered; when 1, writeback must not advance and must re-present the same write next cycle
- llu_valid  input  1  LLU result valid
- llu_ready  output  1  arbiter can accept an LLU result
- llu_dest  input  5  LLU destination register
- llu_data  input  32  LLU result
- rf_we  output  1  regfile write enable
- rf_waddr  output  5  regfile write address
- rf_wdata  output  32  regfile write data
- buf_count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rstn=0 at posedge clk): FIFO empty (buf_count=0), wait counter=0, w_hold=0, all pointers=0. With w_we=0, rf_we=0, rf_waddr=0 and rf_wdata=0.
- llu_ready = (buf_count != DEPTH). It depends only on occupancy. No push while full, even in a cycle that pops.
- Push: on llu_valid && llu_ready at posedge, {llu_dest, llu_data} enters the FIFO tail. If llu_dest==0, the result is accepted and discarded (not enqueued, no count change).
- LLU results are always registered in the FIFO first. Minimum LLU-to-regfile latency is 1 cycle after acceptance; there is no bypass.
- A writeback request is real when w_we && w_dest!=0. A w_we with w_dest==0 is ignored and leaves the port free.
- Grant (combinational, per cycle):
  - If w_hold==0 and the writeback request is real: grant writeback. rf_we=1, rf_waddr=w_dest, rf_wdata=w_data.
  - Else if the FIFO is non-empty: grant the FIFO head. rf_we=1, drive head dest/data, pop at posedge.
  - Else: rf_we=0, rf_waddr=0, rf_wdata=0.
- While w_hold==1, writeback inputs are ignored entirely. Writeback holds its instruction and re-presents it.
- Wait counter:
  - Increments each cycle the FIFO is non-empty and not popped.
  - Clears on any pop, or when the FIFO is empty.
  - Saturates at MAX_WAIT.
- w_hold:
  - Set to 1 at the posedge where the wait counter's next value reaches MAX_WAIT.
  - Stays 1 for exactly one cycle, during which the FIFO head is guaranteed granted.
  - Cleared at the following posedge; the counter clears with the pop.
  - Never asserted in two consecutive cycles.
- Simultaneous push and pop (not full): both happen; buf_count unchanged.
- Pointers wrap modulo DEPTH.
- ex_en/flush does not affect this block. Queued LLU results belong to retired instructions and are always written.
- Ordering between a writeback write and a queued LLU result to the same register is not resolved here. The issue-side scoreboard guarantees no such overlap.

Optional Feature:
- Macro: RF_ARB_PERF_CNT_EN.
- Defined: adds output port conflict_cnt (32 bits). It counts cycles where a real writeback request and a non-empty FIFO coexist, and separately hold_cnt (32 bits) counts w_hold cycles. Both reset to 0, wrap at 2^32.
- Undefined: neither port nor counters exist; behaviour is otherwise identical.

Test Plan:
- Reset then idle: rstn=0 for 2 cycles → rf_we=0, buf_count=0, w_hold=0, llu_ready=1.
- LLU only: llu_valid=1, dest=5, data=0x12345678 for 1 cycle, w_we=0 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x12345678, then buf_count=0.
- Priority: FIFO holds {3,0xAA}, w_we=1 dest=7 data=0x55 → rf_waddr=7. Head written the first cycle w_we=0.
- Starvation (MAX_WAIT=4): FIFO holds {9,0x99}, w_we=1 dest=1 continuously → w_hold=1 in the cycle after the 4th ungranted cycle. That cycle rf_waddr=9, rf_wdata=0x99. Next cycle w_hold=0 and writeback resumes with dest=1.
- Full (DEPTH=2): push 2 results with w_we=1 continuously → llu_ready=0. A push attempt in the pop cycle is rejected; llu_ready=1 the cycle after.
- r0 filtering: llu_dest=0 pushed → buf_count stays 0. w_we=1 with w_dest=0 while FIFO non-empty → head granted that cycle.

Source files
------------

// File: rtl/rf_wport_if.sv
// Write-port bundle between writeback, the long-latency unit and the regfile write port.
// master = requester/regfile side, slave = the rf_wport_arbiter.
interface rf_wport_if #(
  parameter int DEPTH = 2
);
  logic                   w_we;
  logic [4:0]             w_dest;
  logic [31:0]            w_data;
  logic                   w_hold;
  logic                   llu_valid;
  logic                   llu_ready;
  logic [4:0]             llu_dest;
  logic [31:0]            llu_data;
  logic                   rf_we;
  logic [4:0]             rf_waddr;
  logic [31:0]            rf_wdata;
  logic [$clog2(DEPTH):0] buf_count;

  modport master (
    output w_we, w_dest, w_data, llu_valid, llu_dest, llu_data,
    input  w_hold, llu_ready, rf_we, rf_waddr, rf_wdata, buf_count
  );

  modport slave (
    input  w_we, w_dest, w_data, llu_valid, llu_dest, llu_data,
    output w_hold, llu_ready, rf_we, rf_waddr, rf_wdata, buf_count
  );
endinterface

// File: rtl/rf_wport_arbiter.sv
// Regfile write-port arbiter: writeback has priority, LLU results queue in a FIFO with a starvation limiter.
// Optional RF_ARB_PERF_CNT_EN adds conflict_cnt and hold_cnt performance counters.
module rf_wport_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic         clk,
  input  logic         rstn,
  rf_wport_if.slave    bus
`ifdef RF_ARB_PERF_CNT_EN
  ,
  output logic [31:0]  conflict_cnt,
  output logic [31:0]  hold_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [WW-1:0] MAX_W    = WW'(MAX_WAIT);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          hold_q, hold_d;
  logic [4:0]    dest_mem_q [DEPTH];
  logic [4:0]    dest_mem_d [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic [31:0]   data_mem_d [DEPTH];

  logic fifo_empty, fifo_full, wb_real, wb_grant, push, pop;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FULL_CNT);
    wb_real    = bus.w_we && (bus.w_dest != 5'd0);
    wb_grant   = !hold_q && wb_real;
    pop        = !wb_grant && !fifo_empty;
    // r0 results are accepted but never occupy an entry
    push       = bus.llu_valid && !fifo_full && (bus.llu_dest != 5'd0);
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (wb_grant) begin
      rf_we    = 1'b1;
      rf_waddr = bus.w_dest;
      rf_wdata = bus.w_data;
    end else if (pop) begin
      rf_we    = 1'b1;
      rf_waddr = dest_mem_q[rd_ptr_q];
      rf_wdata = data_mem_q[rd_ptr_q];
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    dest_mem_d = dest_mem_q;
    data_mem_d = data_mem_q;
    if (push) begin
      dest_mem_d[wr_ptr_q] = bus.llu_dest;
      data_mem_d[wr_ptr_q] = bus.llu_data;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A hold cycle always pops the head, so the counter clears and hold cannot repeat back to back.
  always_comb begin
    if (fifo_empty || pop) begin
      wait_d = '0;
    end else if (wait_q != MAX_W) begin
      wait_d = wait_q + 1'b1;
    end else begin
      wait_d = wait_q;
    end
    hold_d = !hold_q && (wait_d == MAX_W);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wait_q   <= '0;
      hold_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wait_q   <= wait_d;
      hold_q   <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    dest_mem_q <= dest_mem_d;
    data_mem_q <= data_mem_d;
  end

  assign bus.rf_we     = rf_we;
  assign bus.rf_waddr  = rf_waddr;
  assign bus.rf_wdata  = rf_wdata;
  assign bus.w_hold    = hold_q;
  assign bus.llu_ready = !fifo_full;
  assign bus.buf_count = count_q;

`ifdef RF_ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    hold_cnt_d     = hold_cnt_q;
    if (wb_real && !fifo_empty) conflict_cnt_d = conflict_cnt_q + 32'd1;
    if (hold_q)                 hold_cnt_d     = hold_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      conflict_cnt_q <= '0;
      hold_cnt_q     <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
  assign hold_cnt     = hold_cnt_q;
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed testbench for rf_wport_arbiter (DEPTH=2, MAX_WAIT=4).
module tb_rf_wport_arbiter;

  logic clk = 1'b0;
  logic rstn;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  rf_wport_if #(.DEPTH(2)) bus ();

`ifdef RF_ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt, hold_cnt;
`endif

  rf_wport_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
`ifdef RF_ARB_PERF_CNT_EN
    ,
    .conflict_cnt (conflict_cnt),
    .hold_cnt     (hold_cnt)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] d, input logic [31:0] v);
    bus.w_we = we; bus.w_dest = d; bus.w_data = v;
  endtask

  task automatic set_llu(input logic vld, input logic [4:0] d, input logic [31:0] v);
    bus.llu_valid = vld; bus.llu_dest = d; bus.llu_data = v;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    set_wb(1'b0, 5'd0, 32'd0);
    set_llu(1'b0, 5'd0, 32'd0);
    tick; tick;
    #1;
    n_checks++; if (bus.rf_we !== 1'b0) begin n_errors++; $display("FAIL reset_rf_we got %0b want 0", bus.rf_we); end
    n_checks++; if (bus.rf_waddr !== 5'd0) begin n_errors++; $display("FAIL reset_rf_waddr got %0d want 0", bus.rf_waddr); end
    n_checks++; if (bus.rf_wdata !== 32'd0) begin n_errors++; $display("FAIL reset_rf_wdata got %h want 0", bus.rf_wdata); end
    n_checks++; if (bus.buf_count !== 2'd0) begin n_errors++; $display("FAIL reset_buf_count got %0d want 0", bus.buf_count); end
    n_checks++; if (bus.w_hold !== 1'b0) begin n_errors++; $display("FAIL reset_w_hold got %0b want 0", bus.w_hold); end
    n_checks++; if (bus.llu_ready !== 1'b1) begin n_errors++; $display("FAIL reset_llu_ready got %0b want 1", bus.llu_ready); end
    rstn = 1'b1;
    tick;
  endtask

  task automatic test_llu_only;
    set_llu(1'b1, 5'd5, 32'h1234_5678);
    #1;
    n_checks++; if (bus.rf_we !== 1'b0) begin n_errors++; $display("FAIL llu_no_bypass rf_we got %0b want 0", bus.rf_we); end
    tick;
    set_llu(1'b0, 5'd0, 32'd0);
    #1;
    n_checks++; if (bus.buf_count !== 2'd1) begin n_errors++; $display("FAIL llu_count got %0d want 1", bus.buf_count); end
    n_checks++; if (bus.rf_we !== 1'b1) begin n_errors++; $display("FAIL llu_rf_we got %0b want 1", bus.rf_we); end
    n_checks++; if (bus.rf_waddr !== 5'd5) begin n_errors++; $display("FAIL llu_waddr got %0d want 5", bus.rf_waddr); end
    n_checks++; if (bus.rf_wdata !== 32'h1234_5678) begin n_errors++; $display("FAIL llu_wdata got %h want 12345678", bus.rf_wdata); end
    tick;
    #1;
    n_checks++; if (bus.buf_count !== 2'd0) begin n_errors++; $display("FAIL llu_drained got %0d want 0", bus.buf_count); end
    n_checks++; if (bus.rf_we !== 1'b0) begin n_errors++; $display("FAIL llu_idle_rf_we got %0b want 0", bus.rf_we); end
  endtask

  task automatic test_priority;
    set_llu(1'b1, 5'd3, 32'hAA);
    tick;
    set_llu(1'b0, 5'd0, 32'd0);
    set_wb(1'b1, 5'd7, 32'h55);
    #1;
    n_checks++; if (bus.rf_waddr !== 5'd7) begin n_errors++; $display("FAIL prio_waddr got %0d want 7", bus.rf_waddr); end
    n_checks++; if (bus.rf_wdata !== 32'h55) begin n_errors++; $display("FAIL prio_wdata got %h want 55", bus.rf_wdata); end
    n_checks++; if (bus.buf_count !== 2'd1) begin n_errors++; $display("FAIL prio_count got %0d want 1", bus.buf_count); end
    tick;
    set_wb(1'b0, 5'd0, 32'd0);
    #1;
    n_checks++; if (bus.rf_waddr !== 5'd3) begin n_errors++; $display("FAIL prio_head_waddr got %0d want 3", bus.rf_waddr); end
    n_checks++; if (bus.rf_wdata !== 32'hAA) begin n_errors++; $display("FAIL prio_head_wdata got %h want aa", bus.rf_wdata); end
    tick;
    #1;
    n_checks++; if (bus.buf_count !== 2'd0) begin n_errors++; $display("FAIL prio_drained got %0d want 0", bus.buf_count); end
  endtask

  task automatic test_starvation;
    set_llu(1'b1, 5'd9, 32'h99);
    tick;
    set_llu(1'b0, 5'd0, 32'd0);
    set_wb(1'b1, 5'd1, 32'h11);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (bus.w_hold !== 1'b0 || bus.rf_waddr !== 5'd1) begin n_errors++; $display("FAIL starve_pre%0d hold=%0b waddr=%0d want hold=0 waddr=1", i, bus.w_hold, bus.rf_waddr); end
      tick;
    end
    #1;
    n_checks++; if (bus.w_hold !== 1'b1) begin n_errors++; $display("FAIL starve_hold got %0b want 1", bus.w_hold); end
    n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd9) begin n_errors++; $display("FAIL starve_waddr we=%0b waddr=%0d want we=1 waddr=9", bus.rf_we, bus.rf_waddr); end
    n_checks++; if (bus.rf_wdata !== 32'h99) begin n_errors++; $display("FAIL starve_wdata got %h want 99", bus.rf_wdata); end
    tick;
    #1;
    n_checks++; if (bus.w_hold !== 1'b0) begin n_errors++; $display("FAIL starve_release got %0b want 0", bus.w_hold); end
    n_checks++; if (bus.rf_waddr !== 5'd1 || bus.rf_wdata !== 32'h11) begin n_errors++; $display("FAIL starve_resume waddr=%0d data=%h want 1/11", bus.rf_waddr, bus.rf_wdata); end
    n_checks++; if (bus.buf_count !== 2'd0) begin n_errors++; $display("FAIL starve_count got %0d want 0", bus.buf_count); end
    set_wb(1'b0, 5'd0, 32'd0);
    tick;
  endtask

  task automatic test_full;
    set_wb(1'b1, 5'd2, 32'h22);
    set_llu(1'b1, 5'd10, 32'hA0);
    tick;
    set_llu(1'b1, 5'd11, 32'hB0);
    tick;
    set_llu(1'b1, 5'd12, 32'hC0);
    #1;
    n_checks++; if (bus.llu_ready !== 1'b0) begin n_errors++; $display("FAIL full_ready got %0b want 0", bus.llu_ready); end
    n_checks++; if (bus.buf_count !== 2'd2) begin n_errors++; $display("FAIL full_count got %0d want 2", bus.buf_count); end
    tick; tick;
    #1;
    n_checks++; if (bus.w_hold !== 1'b0) begin n_errors++; $display("FAIL full_prehold got %0b want 0", bus.w_hold); end
    tick;
    #1;
    n_checks++; if (bus.w_hold !== 1'b1 || bus.rf_waddr !== 5'd10) begin n_errors++; $display("FAIL full_pop hold=%0b waddr=%0d want hold=1 waddr=10", bus.w_hold, bus.rf_waddr); end
    n_checks++; if (bus.llu_ready !== 1'b0) begin n_errors++; $display("FAIL full_pop_ready got %0b want 0", bus.llu_ready); end
    tick;
    set_llu(1'b0, 5'd0, 32'd0);
    set_wb(1'b0, 5'd0, 32'd0);
    #1;
    n_checks++; if (bus.llu_ready !== 1'b1 || bus.buf_count !== 2'd1) begin n_errors++; $display("FAIL full_after ready=%0b count=%0d want 1/1", bus.llu_ready, bus.buf_count); end
    n_checks++; if (bus.rf_waddr !== 5'd11 || bus.rf_wdata !== 32'hB0) begin n_errors++; $display("FAIL full_head2 waddr=%0d data=%h want 11/b0", bus.rf_waddr, bus.rf_wdata); end
    tick;
    #1;
    n_checks++; if (bus.buf_count !== 2'd0 || bus.rf_we !== 1'b0) begin n_errors++; $display("FAIL full_rejected count=%0d we=%0b want 0/0", bus.buf_count, bus.rf_we); end
  endtask

  task automatic test_r0;
    set_llu(1'b1, 5'd0, 32'hDEAD);
    tick;
    set_llu(1'b0, 5'd0, 32'd0);
    #1;
    n_checks++; if (bus.buf_count !== 2'd0 || bus.rf_we !== 1'b0) begin n_errors++; $display("FAIL r0_llu count=%0d we=%0b want 0/0", bus.buf_count, bus.rf_we); end
    set_llu(1'b1, 5'd4, 32'h44);
    tick;
    set_llu(1'b0, 5'd0, 32'd0);
    set_wb(1'b1, 5'd0, 32'h77);
    #1;
    n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd4 || bus.rf_wdata !== 32'h44) begin n_errors++; $display("FAIL r0_wb we=%0b waddr=%0d data=%h want 1/4/44", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    tick;
    #1;
    n_checks++; if (bus.buf_count !== 2'd0 || bus.rf_we !== 1'b0) begin n_errors++; $display("FAIL r0_idle count=%0d we=%0b want 0/0", bus.buf_count, bus.rf_we); end
    set_wb(1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_back_to_back;
    set_llu(1'b1, 5'd6, 32'h66);
    tick;
    set_llu(1'b1, 5'd8, 32'h88);
    #1;
    n_checks++; if (bus.rf_waddr !== 5'd6 || bus.rf_wdata !== 32'h66) begin n_errors++; $display("FAIL b2b_first waddr=%0d data=%h want 6/66", bus.rf_waddr, bus.rf_wdata); end
    tick;
    set_llu(1'b0, 5'd0, 32'd0);
    #1;
    n_checks++; if (bus.buf_count !== 2'd1) begin n_errors++; $display("FAIL b2b_count got %0d want 1", bus.buf_count); end
    n_checks++; if (bus.rf_waddr !== 5'd8 || bus.rf_wdata !== 32'h88) begin n_errors++; $display("FAIL b2b_second waddr=%0d data=%h want 8/88", bus.rf_waddr, bus.rf_wdata); end
    tick;
    #1;
    n_checks++; if (bus.buf_count !== 2'd0) begin n_errors++; $display("FAIL b2b_drained got %0d want 0", bus.buf_count); end
  endtask

  initial begin
    rstn = 1'b0;
    set_wb(1'b0, 5'd0, 32'd0);
    set_llu(1'b0, 5'd0, 32'd0);
    test_reset;
    test_llu_only;
    test_priority;
    test_starvation;
    test_full;
    test_r0;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
